// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - instruction fetch stage with decoupling queue and redirect; optional FETCH_PERF_EN perf counters
module fetch_queue_if #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000,
  parameter int          FQ_DEPTH = 4,
  parameter int          ORDER_W  = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dmem_req,
  output logic [31:0]        imem_addr,
  output logic [3:0]         imem_rmask,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_resp,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_pc_next,
  output logic [31:0]        out_inst,
  output logic [ORDER_W-1:0] out_order
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_stall_cycles,
  output logic [31:0]        perf_redirects
`endif
);

  localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);

  logic [31:0]        pc;
  logic [31:0]        req_pc;
  logic               outstanding;
  logic               stale;
  logic [ORDER_W-1:0] order;

  logic [31:0]        fq_pc   [FQ_DEPTH];
  logic [31:0]        fq_inst [FQ_DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;

  logic resp_fire;
  logic push;
  logic pop;
  logic busy;
  logic room;
  logic issue;

  // A response retires the outstanding request in its own cycle, so the next
  // fetch can go out immediately; the queue slot it fills is counted up front.
  always_comb begin
    resp_fire = imem_resp && outstanding;
    push      = resp_fire && !stale && !redirect_valid;
    busy      = outstanding && !resp_fire;
    room      = (count + CNT_W'(push)) < DEPTH_C;
    issue     = !rst && !redirect_valid && !busy && !dmem_req && room;
    out_valid = (count != '0) && !redirect_valid;
    pop       = out_valid && out_ready;
  end

  always_comb begin
    imem_addr   = pc;
    imem_rmask  = issue ? 4'hF : 4'h0;
    out_pc      = fq_pc[head];
    out_inst    = fq_inst[head];
    out_pc_next = fq_pc[head] + 32'd4;
    out_order   = order;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      req_pc      <= RESET_PC;
      outstanding <= 1'b0;
      stale       <= 1'b0;
    end else if (redirect_valid) begin
      pc          <= redirect_pc & 32'hFFFF_FFFC;
      // An in-flight request keeps the port busy but its word must be thrown away.
      outstanding <= busy;
      stale       <= busy;
    end else begin
      if (issue) begin
        pc          <= pc + 32'd4;
        req_pc      <= pc;
        outstanding <= 1'b1;
      end else if (resp_fire) begin
        outstanding <= 1'b0;
      end
      if (resp_fire) begin
        stale <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fq_pc[tail]   <= req_pc;
      fq_inst[tail] <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      order <= '0;
    end else if (pop) begin
      order <= order + ORDER_W'(1);
    end
  end

`ifdef FETCH_PERF_EN
  logic stall_cond;

  always_comb begin
    stall_cond = !rst && !redirect_valid && !busy && (dmem_req || !room);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_redirects    <= '0;
    end else begin
      if (stall_cond && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
      if (redirect_valid && (perf_redirects != 32'hFFFF_FFFF)) begin
        perf_redirects <= perf_redirects + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/fetch_queue_if.md
Name: fetch_queue_if

Overview:
Parametrised instruction-fetch stage with a decoupling fetch queue and redirect support. It owns the PC and issues 4-byte reads on the instruction memory port, with at most one request outstanding. Returned words are buffered in a FIFO of FQ_DEPTH entries and handed to decode through a valid/ready interface. A redirect from later stages flushes the queue, squashes any in-flight response and restarts fetch at a new PC.

Parameters:
RESET_PC, 32'h1eceb000, PC loaded on reset.
FQ_DEPTH, 4, fetch-queue entries; power of two, 2..16.
ORDER_W, 64, width of the retirement order tag.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
dmem_req  in  1  data-side request this cycle; fetch issue is suppressed while high
imem_addr  out  32  fetch address; equals pc
imem_rmask  out  4  4'hF for exactly the issue cycle, else 4'h0
imem_rdata  in  32  returned instruction word
imem_resp  in  1  one-cycle response strobe for the outstanding request
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  32  new fetch PC; low 2 bits ignored (forced 0)
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_pc  out  32  PC of head
out_pc_next  out  32  out_pc + 4
out_inst  out  32  instruction word of head
out_order  out  ORDER_W  order tag of head

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - pc=RESET_PC, queue empty, outstanding=0, stale=0, order=0.
  - out_valid=0, imem_rmask=0, imem_addr=RESET_PC.
- Issue condition, all must hold: !rst, !redirect_valid, !outstanding, !dmem_req, and (count + 1) <= FQ_DEPTH.
  - The +1 reserves a slot for the in-flight word.
- Issue cycle:
  - imem_rmask=4'hF, imem_addr=pc.
  - Next cycle: outstanding=1, pc=pc+4 (wraps mod 2^32), and the issued PC is latched as req_pc.
- Response (imem_resp while outstanding):
  - If stale=0: push {req_pc, imem_rdata}.
  - Otherwise drop the word.
  - Either way, clear outstanding and stale.
  - A new issue may occur in the same cycle as a response (back-to-back fetch).
- imem_resp while !outstanding is ignored.
- Minimum fetch-to-out_valid latency: 2 cycles after issue when the response arrives one cycle after issue.
- Dequeue on out_valid && out_ready.
  - out_order holds the current order; order increments by 1 per dequeue, wrapping at ORDER_W.
  - Squashed instructions never consume an order value.
- Push and pop in the same cycle while full: legal; count is unchanged.
- Redirect_valid has priority over everything:
  - Queue is flushed next cycle.
  - out_valid is forced 0 in the redirect cycle, so no dequeue and no order increment occur.
  - pc=redirect_pc next cycle.
  - If a request is outstanding and no response arrives in the same cycle, stale=1.
  - A response arriving in the redirect cycle is dropped.
  - No issue occurs in the redirect cycle.
  - Issue resumes once outstanding=0.
- Back-to-back redirects: the last one wins; stale stays set.
- Reset mid-operation:
  - Any outstanding request is abandoned and its later response is ignored.
  - The queue empties and order returns to 0.
- out_* fields are driven directly from the head entry, with no combinational path from imem_* to out_*.

Optional Feature:
Macro: FETCH_PERF_EN.
- Defined: adds output ports perf_stall_cycles[31:0] and perf_redirects[31:0].
  - perf_stall_cycles counts cycles where the issue condition fails only because of dmem_req or a full queue.
  - perf_redirects counts cycles with redirect_valid high.
  - Both reset to 0 and saturate at 32'hFFFFFFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, imem_resp 1 cycle after each issue, out_ready=1:
  - imem_addr sequence is 1eceb000, 1eceb004, 1eceb008.
  - out_pc matches that sequence with out_order 0, 1, 2.
  - out_pc_next = out_pc+4.
- out_ready=0, responses immediate:
  - Exactly FQ_DEPTH=4 issues, then imem_rmask stays 0.
  - Raising out_ready resumes issue one cycle after the first dequeue.
- dmem_req held high 3 cycles: no imem_rmask pulse during those cycles; issue resumes on the cycle dmem_req falls.
- Redirect to 32'h1eceb100 while a request is outstanding, response 2 cycles later:
  - The stale word is dropped and the queue is empty.
  - The next issue is at 1eceb100.
  - The next out_order continues from the pre-redirect value.
- Redirect in the same cycle as imem_resp and out_ready=1:
  - Nothing is dequeued and the word is dropped.
  - order is unchanged.
- rst asserted mid-stream with a request outstanding:
  - pc=1eceb000, out_valid=0, order=0.
  - A late imem_resp is ignored and the first post-reset output is 1eceb000, order 0.
